vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Source end of the pixel-stream interface that the filter chain consumes. Generates x_pixel/y_pixel/DE and h_sync/v_sync for 640x480@60 from sys_clk via a pixel-enable divider. Issues a one-pixel-ahead read address into the 320x240 QVGA frame buffer, so that buffer data (1 pclk read latency) aligns with DE at the filter inputs. Sits between the frame buffer and the filter/VGA output path.

Parameters:
CLK_DIV, 4, sys_clk cycles per pixel (>=2)
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SW, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SW, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_ACT, 0, active level of h_sync/v_sync

Ports:
sys_clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pclk_en  out  1  one-sys_clk pixel strobe, every CLK_DIV cycles
x_pixel  out  10  horizontal counter, 0..H_TOTAL-1
y_pixel  out  10  vertical counter, 0..V_TOTAL-1
DE  out  1  high when x_pixel<H_VIS and y_pixel<V_VIS
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
rd_addr  out  17  QVGA frame-buffer address of the next pixel
frame_done  out  1  one-sys_clk pulse at the end of the last pixel of each frame

Behaviour:
- Totals: H_TOTAL = H_VIS+H_FP+H_SW+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SW+V_BP (525).
- Reset (async, immediate): div_cnt=0, pclk_en=0, x_pixel=0, y_pixel=0, DE=0, h_sync=v_sync=!SYNC_ACT, rd_addr=0, frame_done=0.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. pclk_en is registered and high during the cycle after div_cnt==CLK_DIV-1. First pclk_en occurs in sys_clk cycle CLK_DIV after reset release.
- Advance: on each edge where pclk_en=1:
  - x_pixel increments; wraps H_TOTAL-1 -> 0.
  - On that wrap, y_pixel increments; wraps V_TOTAL-1 -> 0.
- Registered decodes: DE, h_sync, v_sync and rd_addr are computed from the next counter values, so they change on the same edge as x/y. All outputs hold stable for CLK_DIV sys_clk cycles.
- Sync windows:
  - h_sync=SYNC_ACT for x in [H_VIS+H_FP, H_VIS+H_FP+H_SW-1] = [656,751].
  - v_sync=SYNC_ACT for y in [V_VIS+V_FP, V_VIS+V_FP+V_SW-1] = [490,491].
  - Otherwise each sync is !SYNC_ACT.
- rd_addr: (nx,ny) is the pixel presented at the following pclk_en, including line and frame wrap.
  - If nx<H_VIS and ny<V_VIS: rd_addr = (ny>>1)*320 + (nx>>1). Use a shift-add, no multiplier: (ny>>1)<<8 + (ny>>1)<<6.
  - Otherwise rd_addr = 0.
  - Range 0..76799.
- frame_done: high for exactly the one sys_clk cycle in which pclk_en=1 and x=H_TOTAL-1, y=V_TOTAL-1. No pulse after reset until the first full frame completes.
- Reset mid-frame: all outputs return to reset values asynchronously. Counting restarts from (0,0) with a fresh divider phase. No partial frame_done is generated.

Optional Feature:
TEST_PATTERN_EN
- Defined: adds outputs r_tp, g_tp, b_tp (4 bits each), registered with the same timing as DE.
  - When DE=1: 8 vertical bars of 80 px, index x_pixel/80, colours in order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - When DE=0: 000.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Release reset, run 4*800 sys_clk -> pclk_en period exactly 4; x_pixel steps 0..799 and wraps to 0; y_pixel steps 0->1 on that wrap.
- Scan one full line at y=10 -> DE high for x 0..639 (640 pixels); h_sync=0 for x 656..751 (96 pixels), 1 elsewhere; DE=0 on lines 480..524.
- Run two frames -> v_sync=0 only on lines 490..491; frame_done pulses 1,680,000 sys_clk apart, each one cycle wide, coincident with (799,524).
- Check rd_addr at selected positions:
  - at (3,2) -> 322
  - at (799,1) -> 320
  - at (0,0) -> 0, then 1 at (1,0)
  - at (799,479) -> 0
  - at (639,5) -> 0
  - at (638,479) -> 76799
- Assert reset for 3 cycles at x=300,y=100 -> outputs go to reset values in the same cycle, without waiting for a clock edge; after release the first pclk_en lands at cycle 4 and x restarts at 0; no spurious frame_done.
- With TEST_PATTERN_EN -> x=85,y=20 gives {FF0}; x=639 gives {000}; x=700 (DE=0) gives {000}.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 pixel timing (x/y, DE, syncs) from sys_clk plus a one-pixel-ahead
// QVGA frame-buffer read address. Optional colour-bar outputs r_tp/g_tp/b_tp under TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SW     = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SW     = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_ACT = 0
) (
  input  logic        sys_clk,
  input  logic        reset,
  output logic        pclk_en,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic        DE,
  output logic        h_sync,
  output logic        v_sync,
  output logic [16:0] rd_addr,
  output logic        frame_done
`ifdef TEST_PATTERN_EN
  ,
  output logic [3:0]  r_tp,
  output logic [3:0]  g_tp,
  output logic [3:0]  b_tp
`endif
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SW - 1);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SW - 1);
  localparam logic       SYNC_ON = 1'(SYNC_ACT);

  logic [DIV_W-1:0] div_cnt;
  logic             div_last;
  logic [9:0]       nx, ny, nnx, nny;
  logic             de_next, hs_next, vs_next;
  logic [16:0]      half_y, addr_next;

  // (nx,ny) is the pixel shown after the next strobe; (nnx,nny) is the one after that,
  // whose address must already be on rd_addr to absorb the buffer's one-pixel read latency.
  always_comb begin
    div_last = (div_cnt == DIV_LAST);

    nx = (x_pixel == X_LAST) ? 10'd0 : x_pixel + 10'd1;
    ny = y_pixel;
    if (x_pixel == X_LAST) ny = (y_pixel == Y_LAST) ? 10'd0 : y_pixel + 10'd1;

    nnx = (nx == X_LAST) ? 10'd0 : nx + 10'd1;
    nny = ny;
    if (nx == X_LAST) nny = (ny == Y_LAST) ? 10'd0 : ny + 10'd1;

    de_next = (nx < H_VIS_W) && (ny < V_VIS_W);
    hs_next = (nx >= HS_BEG && nx <= HS_END) ? SYNC_ON : ~SYNC_ON;
    vs_next = (ny >= VS_BEG && ny <= VS_END) ? SYNC_ON : ~SYNC_ON;

    // QVGA row stride of 320 = 256 + 64
    half_y    = 17'(nny[9:1]);
    addr_next = 17'd0;
    if (nnx < H_VIS_W && nny < V_VIS_W)
      addr_next = (half_y << 8) + (half_y << 6) + 17'(nnx[9:1]);
  end

  // pclk_en is a strobe: every other output only moves on a sys_clk edge where it is high.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      pclk_en    <= 1'b0;
      x_pixel    <= 10'd0;
      y_pixel    <= 10'd0;
      DE         <= 1'b0;
      h_sync     <= ~SYNC_ON;
      v_sync     <= ~SYNC_ON;
      rd_addr    <= 17'd0;
      frame_done <= 1'b0;
    end else begin
      div_cnt    <= div_last ? '0 : div_cnt + DIV_W'(1);
      pclk_en    <= div_last;
      frame_done <= div_last && (x_pixel == X_LAST) && (y_pixel == Y_LAST);
      if (pclk_en) begin
        x_pixel <= nx;
        y_pixel <= ny;
        DE      <= de_next;
        h_sync  <= hs_next;
        v_sync  <= vs_next;
        rd_addr <= addr_next;
      end
    end
  end

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_VIS / 8;

  logic [2:0] bar_idx;
  logic [3:0] r_next, g_next, b_next;

  // Bar colour bits fall straight out of the bar index: r=~idx[1], g=~idx[2], b=~idx[0].
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++)
      if (nx >= 10'(i * BAR_W)) bar_idx = 3'(i);
    r_next = (de_next && !bar_idx[1]) ? 4'hF : 4'h0;
    g_next = (de_next && !bar_idx[2]) ? 4'hF : 4'h0;
    b_next = (de_next && !bar_idx[0]) ? 4'hF : 4'h0;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      r_tp <= 4'h0;
      g_tp <= 4'h0;
      b_tp <= 4'h0;
    end else if (pclk_en) begin
      r_tp <= r_next;
      g_tp <= g_next;
      b_tp <= b_next;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen; a default 640x480 instance and a
// shrunken instance (CLK_DIV=2, active-high syncs) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int A_DIV = 4, A_HV = 640, A_HT = 800, A_VV = 480, A_VT = 525;
  localparam int B_DIV = 2, B_HV = 16, B_HT = 24, B_VV = 8, B_VT = 15;
  localparam int B_FRAME = B_HT * B_VT * B_DIV;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  logic        a_pclk, a_de, a_hs, a_vs, a_fd;
  logic [9:0]  a_x, a_y;
  logic [16:0] a_rd;
  logic        b_pclk, b_de, b_hs, b_vs, b_fd;
  logic [9:0]  b_x, b_y;
  logic [16:0] b_rd;
`ifdef TEST_PATTERN_EN
  logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;
`endif

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  int a_pclk_bad = 0, a_pos_bad = 0, a_de_bad = 0, a_hs_bad = 0, a_vs_bad = 0;
  int a_rd_bad = 0, a_fd_bad = 0;
  int l10_de = 0, l10_hs = 0, l10_hs_first = -1, l10_hs_last = -1;
  int b_pclk_bad = 0, b_pos_bad = 0, b_de_bad = 0, b_hs_bad = 0, b_vs_bad = 0;
  int b_rd_bad = 0, b_fd_bad = 0, b_fd_cnt = 0, b_fd_c1 = -1, b_fd_c2 = -1, b_vs_lines = 0;

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .sys_clk(clk), .reset(rst_a), .pclk_en(a_pclk), .x_pixel(a_x), .y_pixel(a_y),
    .DE(a_de), .h_sync(a_hs), .v_sync(a_vs), .rd_addr(a_rd), .frame_done(a_fd)
`ifdef TEST_PATTERN_EN
    , .r_tp(a_r), .g_tp(a_g), .b_tp(a_b)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_VIS(16), .H_FP(2), .H_SW(3), .H_BP(3),
    .V_VIS(8), .V_FP(2), .V_SW(2), .V_BP(3), .SYNC_ACT(1)
  ) dut_b (
    .sys_clk(clk), .reset(rst_b), .pclk_en(b_pclk), .x_pixel(b_x), .y_pixel(b_y),
    .DE(b_de), .h_sync(b_hs), .v_sync(b_vs), .rd_addr(b_rd), .frame_done(b_fd)
`ifdef TEST_PATTERN_EN
    , .r_tp(b_r), .g_tp(b_g), .b_tp(b_b)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
    end
  endtask

  function automatic int nxt_x(input int x, input int ht);
    return (x == ht - 1) ? 0 : x + 1;
  endfunction

  function automatic int nxt_y(input int x, input int y, input int ht, input int vt);
    if (x != ht - 1) return y;
    return (y == vt - 1) ? 0 : y + 1;
  endfunction

  function automatic int addr_of(input int x, input int y, input int hv, input int vv);
    if (x < hv && y < vv) return (y / 2) * 320 + (x / 2);
    return 0;
  endfunction

  function automatic logic [11:0] bar_rgb(input int x);
    logic [11:0] tbl [8];
    tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return tbl[x / 80];
  endfunction

  // Cycle c counts sys_clk edges since reset release; pixel p=(c-1)/DIV is on screen.
  task automatic run_a(input int n_cyc);
    int p, mx, my;
    logic first, exp_pclk;
    for (int c = 1; c <= n_cyc; c++) begin
      cyc();
      p = (c - 1) / A_DIV;
      mx = p % A_HT;
      my = (p / A_HT) % A_VT;
      first = ((c - 1) % A_DIV == 0);
      exp_pclk = ((c % A_DIV) == 0);
      if (a_pclk !== exp_pclk) a_pclk_bad++;
      if (a_x !== 10'(mx) || a_y !== 10'(my)) a_pos_bad++;
      if (a_de !== ((p > 0) && mx < A_HV && my < A_VV)) a_de_bad++;
      if (a_hs !== ((mx >= 656 && mx <= 751) ? 1'b0 : 1'b1)) a_hs_bad++;
      if (a_vs !== ((my >= 490 && my <= 491) ? 1'b0 : 1'b1)) a_vs_bad++;
      if (a_rd !== 17'(addr_of(nxt_x(mx, A_HT), nxt_y(mx, my, A_HT, A_VT), A_HV, A_VV))) a_rd_bad++;
      if (a_fd !== (exp_pclk && mx == A_HT - 1 && my == A_VT - 1)) a_fd_bad++;
      if (first && my == 10) begin
        if (a_de === 1'b1) l10_de++;
        if (a_hs === 1'b0) begin
          l10_hs++;
          if (l10_hs_first < 0) l10_hs_first = int'(a_x);
          l10_hs_last = int'(a_x);
        end
      end
      if (c == 3) begin push_exp(0); check("a_pclk_cycle3", 32'(a_pclk)); end
      if (c == 4) begin
        push_exp(1); check("a_pclk_cycle4", 32'(a_pclk));
        push_exp(0); check("a_x_cycle4", 32'(a_x));
      end
      if (c == 5) begin push_exp(1); check("a_x_cycle5", 32'(a_x)); end
      if (first) begin
        if (mx == 0 && my == 0) begin push_exp(0); check("a_rd_0_0", 32'(a_rd)); end
        if (mx == 1 && my == 0) begin push_exp(1); check("a_rd_1_0", 32'(a_rd)); end
        if (mx == 3 && my == 2) begin push_exp(322); check("a_rd_3_2", 32'(a_rd)); end
        if (mx == 799 && my == 1) begin push_exp(320); check("a_rd_799_1", 32'(a_rd)); end
        if (mx == 639 && my == 5) begin push_exp(0); check("a_rd_639_5", 32'(a_rd)); end
        if (mx == 0 && my == 1) begin
          push_exp(0); check("a_x_wrap", 32'(a_x));
          push_exp(1); check("a_y_step", 32'(a_y));
        end
`ifdef TEST_PATTERN_EN
        if (my == 10 && (mx == 0 || mx == 85 || mx == 639)) begin
          push_exp(32'(bar_rgb(mx))); check("a_tp_bar", 32'({a_r, a_g, a_b}));
        end
        if (my == 10 && mx == 700) begin push_exp(0); check("a_tp_blank", 32'({a_r, a_g, a_b})); end
`endif
      end
    end
  endtask

  task automatic run_b(input int n_cyc);
    int p, mx, my;
    logic first, exp_pclk;
    for (int c = 1; c <= n_cyc; c++) begin
      cyc();
      p = (c - 1) / B_DIV;
      mx = p % B_HT;
      my = (p / B_HT) % B_VT;
      first = ((c - 1) % B_DIV == 0);
      exp_pclk = ((c % B_DIV) == 0);
      if (b_pclk !== exp_pclk) b_pclk_bad++;
      if (b_x !== 10'(mx) || b_y !== 10'(my)) b_pos_bad++;
      if (b_de !== ((p > 0) && mx < B_HV && my < B_VV)) b_de_bad++;
      if (b_hs !== ((mx >= 18 && mx <= 20) ? 1'b1 : 1'b0)) b_hs_bad++;
      if (b_vs !== ((my >= 10 && my <= 11) ? 1'b1 : 1'b0)) b_vs_bad++;
      if (b_rd !== 17'(addr_of(nxt_x(mx, B_HT), nxt_y(mx, my, B_HT, B_VT), B_HV, B_VV))) b_rd_bad++;
      if (b_fd !== (exp_pclk && mx == B_HT - 1 && my == B_VT - 1)) b_fd_bad++;
      if (b_fd === 1'b1) begin
        b_fd_cnt++;
        if (b_fd_c1 < 0) b_fd_c1 = c;
        else if (b_fd_c2 < 0) b_fd_c2 = c;
      end
      if (first && mx == 0 && b_vs === 1'b1) b_vs_lines++;
      if (first && p < B_HT * B_VT) begin
        if (mx == 14 && my == 7) begin push_exp(967); check("b_rd_last_vis", 32'(b_rd)); end
        if (mx == 15 && my == 3) begin push_exp(0); check("b_rd_line_end", 32'(b_rd)); end
        if (mx == 23 && my == 7) begin push_exp(0); check("b_rd_to_blank", 32'(b_rd)); end
        if (mx == 23 && my == 1) begin push_exp(320); check("b_rd_line_wrap", 32'(b_rd)); end
      end
      if (first && p == B_HT * B_VT) begin
        push_exp(1); check("b_de_frame2_origin", 32'(b_de));
        push_exp(0); check("b_rd_frame2_origin", 32'(b_rd));
      end
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #2;
    // Reset values appear before any clock edge.
    push_exp(0); check("a_rst_pclk", 32'(a_pclk));
    push_exp(0); check("a_rst_x", 32'(a_x));
    push_exp(0); check("a_rst_y", 32'(a_y));
    push_exp(0); check("a_rst_de", 32'(a_de));
    push_exp(1); check("a_rst_hs", 32'(a_hs));
    push_exp(1); check("a_rst_vs", 32'(a_vs));
    push_exp(0); check("a_rst_rd", 32'(a_rd));
    push_exp(0); check("a_rst_fd", 32'(a_fd));
    push_exp(0); check("b_rst_hs", 32'(b_hs));
    push_exp(0); check("b_rst_vs", 32'(b_vs));
    cyc();
    cyc();

    rst_b = 1'b0;
    run_b(2 * B_FRAME + 10);
    rst_b = 1'b1;
    push_exp(0); check("b_pclk_bad", 32'(b_pclk_bad));
    push_exp(0); check("b_pos_bad", 32'(b_pos_bad));
    push_exp(0); check("b_de_bad", 32'(b_de_bad));
    push_exp(0); check("b_hs_bad", 32'(b_hs_bad));
    push_exp(0); check("b_vs_bad", 32'(b_vs_bad));
    push_exp(0); check("b_rd_bad", 32'(b_rd_bad));
    push_exp(0); check("b_fd_bad", 32'(b_fd_bad));
    push_exp(2); check("b_fd_count", 32'(b_fd_cnt));
    push_exp(B_FRAME); check("b_fd_first_cycle", 32'(b_fd_c1));
    push_exp(B_FRAME); check("b_fd_spacing", 32'(b_fd_c2 - b_fd_c1));
    push_exp(4); check("b_vs_lines", 32'(b_vs_lines));

    cyc();
    rst_a = 1'b0;
    // Runs up to pixel (300,11).
    run_a((11 * A_HT + 300) * A_DIV + 2);
    push_exp(300); check("a_pre_rst_x", 32'(a_x));
    push_exp(11); check("a_pre_rst_y", 32'(a_y));
    #2;
    rst_a = 1'b1;
    #1;
    push_exp(0); check("a_mid_rst_x", 32'(a_x));
    push_exp(0); check("a_mid_rst_y", 32'(a_y));
    push_exp(0); check("a_mid_rst_de", 32'(a_de));
    push_exp(1); check("a_mid_rst_hs", 32'(a_hs));
    push_exp(1); check("a_mid_rst_vs", 32'(a_vs));
    push_exp(0); check("a_mid_rst_rd", 32'(a_rd));
    push_exp(0); check("a_mid_rst_pclk", 32'(a_pclk));
    cyc();
    cyc();
    cyc();
    push_exp(0); check("a_rst_hold_x", 32'(a_x));
    rst_a = 1'b0;
    run_a(12 * A_DIV);

    push_exp(0); check("a_pclk_bad", 32'(a_pclk_bad));
    push_exp(0); check("a_pos_bad", 32'(a_pos_bad));
    push_exp(0); check("a_de_bad", 32'(a_de_bad));
    push_exp(0); check("a_hs_bad", 32'(a_hs_bad));
    push_exp(0); check("a_vs_bad", 32'(a_vs_bad));
    push_exp(0); check("a_rd_bad", 32'(a_rd_bad));
    push_exp(0); check("a_fd_bad", 32'(a_fd_bad));
    push_exp(640); check("line10_de_count", 32'(l10_de));
    push_exp(96); check("line10_hs_count", 32'(l10_hs));
    push_exp(656); check("line10_hs_first", 32'(l10_hs_first));
    push_exp(751); check("line10_hs_last", 32'(l10_hs_last));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
